mmu_8722: RTL and testbench

- Memory management unit feeding the 8721 PLA in the C128 core.
- Holds the CPU-visible MMU register file: CR, PCRA-D, MCR, RCR, P0L/P0H, P1L/P1H and VR.
- Generates the mode/bank selects ms0-ms3 and z80en for the PLA.
- Relocates the zero page and stack page, and produces the RAM bank select for CPU and VIC cycles.

---
 rtl/mmu_8722.sv | 185 ++++++++++++++++++
 tb/tb_mmu_8722.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mmu_8722.sv
// mmu_8722: C128 memory management unit. Holds the MMU register file,
// drives the PLA mode selects, relocates zero/stack pages and selects the
// RAM bank for CPU and VIC cycles.
module mmu_8722 #(
  parameter logic [7:0] VERSION   = 8'h20,
  parameter logic [7:0] PG1_RESET = 8'h01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        phi2,
  input  logic        aec,
  input  logic        rw,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dout_en,
  input  logic        game,
  input  logic        exrom,
  input  logic        key4080,
  output logic        ms0,
  output logic        ms1,
  output logic        ms2,
  output logic        ms3,
  output logic        z80en,
  output logic        fsdir,
  output logic [7:0]  ta,
  output logic [1:0]  ram_bank
);

  logic [7:0] r_cr;
  logic [7:0] r_pcr [0:3];
  logic       r_mcr0, r_mcr3, r_mcr6;
  logic [7:0] r_rcr;
  logic [7:0] r_p0l, r_p0h_hold, r_p1l, r_p1h_hold;
  logic [1:0] r_p0h, r_p1h;    // only the bank bits of the live high pointers matter
  logic       r_phi2_q;

  logic       w_ms3;
  logic       w_ff_sel, w_io_page, w_io_reg, w_dec, w_commit;
  logic [1:0] w_pidx;
  logic [7:0] w_page, w_mask;
  logic       w_hit, w_shared;

  assign w_ms3     = ~r_mcr6;
  assign w_page    = a[15:8];
  // $FF00-$FF04 while the MMU is visible; $D5xx only when I/O is also banked in.
  assign w_ff_sel  = w_ms3 && (w_page == 8'hFF) && (a[7:0] <= 8'h04);
  assign w_io_page = w_ms3 && !r_cr[0] && (w_page == 8'hD5);
  assign w_io_reg  = w_io_page && (a[7:0] <= 8'h0B);
  assign w_dec     = w_ff_sel || w_io_page;
  // One commit per CPU cycle: the clk edge that sees phi2 fall.
  assign w_commit  = r_phi2_q && !phi2 && !rw && aec && (w_ff_sel || w_io_reg);
  // Maps register offsets 1..4 onto PCR index 0..3.
  assign w_pidx    = a[1:0] - 2'd1;

  // Register file updates on a committed CPU write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phi2_q   <= 1'b0;
      r_cr       <= 8'h00;
      r_pcr[0]   <= 8'h00;
      r_pcr[1]   <= 8'h00;
      r_pcr[2]   <= 8'h00;
      r_pcr[3]   <= 8'h00;
      r_mcr0     <= 1'b0;
      r_mcr3     <= 1'b0;
      r_mcr6     <= 1'b0;
      r_rcr      <= 8'h00;
      r_p0l      <= 8'h00;
      r_p0h      <= 2'b00;
      r_p0h_hold <= 8'h00;
      r_p1l      <= PG1_RESET;
      r_p1h      <= 2'b00;
      r_p1h_hold <= 8'h00;
    end else begin
      r_phi2_q <= phi2;
      if (w_commit) begin
        if (w_ff_sel) begin
          // $FF01-4 are load registers: the data byte is ignored.
          if (a[3:0] == 4'h0) r_cr <= din;
          else                r_cr <= r_pcr[w_pidx];
        end else begin
          case (a[3:0])
            4'h0: r_cr <= din;
            4'h1, 4'h2, 4'h3, 4'h4: r_pcr[w_pidx] <= din;
            4'h5: begin
              r_mcr0 <= din[0];
              r_mcr3 <= din[3];
              r_mcr6 <= din[6];
            end
            4'h6: r_rcr <= din;
            // Low-pointer write takes the staged high byte in the same edge.
            4'h7: begin
              r_p0l <= din;
              r_p0h <= r_p0h_hold[1:0];
            end
            4'h8: r_p0h_hold <= din;
            4'h9: begin
              r_p1l <= din;
              r_p1h <= r_p1h_hold[1:0];
            end
            4'hA: r_p1h_hold <= din;
            default: ;
          endcase
        end
      end
    end
  end

  // Register read-back mux; unused $D5xx offsets read as $FF.
  always_comb begin
    dout = 8'hFF;
    if (w_ff_sel) begin
      if (a[3:0] == 4'h0) dout = r_cr;
      else                dout = r_pcr[w_pidx];
    end else if (w_io_page) begin
      if (a[7:4] == 4'h0) begin
        case (a[3:0])
          4'h0: dout = r_cr;
          4'h1, 4'h2, 4'h3, 4'h4: dout = r_pcr[w_pidx];
          4'h5: dout = {key4080, r_mcr6, exrom, game, r_mcr3, 1'b1, 1'b1, r_mcr0};
          4'h6: dout = r_rcr;
          4'h7: dout = r_p0l;
          4'h8: dout = r_p0h_hold;
          4'h9: dout = r_p1l;
          4'hA: dout = r_p1h_hold;
          4'hB: dout = VERSION;
          default: dout = 8'hFF;
        endcase
      end
    end
  end

  assign dout_en = rw && aec && phi2 && w_dec;

  // PLA mode selects.
  always_comb begin
    ms3   = w_ms3;
    ms2   = r_cr[0];
    z80en = r_mcr0;
    fsdir = r_mcr3;
    {ms1, ms0} = 2'b00;
    if (w_ms3) begin
      case (a[15:14])
        2'b00: {ms1, ms0} = 2'b00;
        2'b01: {ms1, ms0} = r_cr[1] ? 2'b11 : 2'b00;
        2'b10: {ms1, ms0} = {r_cr[2], r_cr[3]};
        default: {ms1, ms0} = {r_cr[4], r_cr[5]};
      endcase
    end
  end

  // Shared-RAM window as a mask on address bits 15:8.
  always_comb begin
    case (r_rcr[1:0])
      2'b00: w_mask = 8'hFC;
      2'b01: w_mask = 8'hF0;
      2'b10: w_mask = 8'hE0;
      default: w_mask = 8'hC0;
    endcase
    w_shared = (r_rcr[2] && ((w_page & w_mask) == 8'h00)) ||
               (r_rcr[3] && ((w_page & w_mask) == w_mask));
  end

  // Page relocation and bank selection; page 0 rules win over page 1.
  always_comb begin
    ta       = w_page;
    ram_bank = r_cr[7:6];
    w_hit    = 1'b0;
    if (aec && w_ms3) begin
      if ((r_p0l != 8'h00) && (w_page == 8'h00)) begin
        ta = r_p0l; ram_bank = r_p0h; w_hit = 1'b1;
      end else if ((r_p0l != 8'h00) && (w_page == r_p0l)) begin
        ta = 8'h00; ram_bank = 2'b00; w_hit = 1'b1;
      end else if (w_page == 8'h01) begin
        ta = r_p1l; ram_bank = r_p1h; w_hit = 1'b1;
      end else if (w_page == r_p1l) begin
        ta = 8'h01; ram_bank = 2'b00; w_hit = 1'b1;
      end
    end
    if (!w_hit && w_shared) ram_bank = 2'b00;
    if (!aec) ram_bank = r_rcr[7:6];
  end

endmodule

// File: tb/tb_mmu_8722.sv
// tb_mmu_8722: directed checks of the MMU register file, mode selects,
// page relocation, shared RAM and C64 lock-out.
module tb_mmu_8722;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        phi2 = 1'b0, aec = 1'b1, rw = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        game = 1'b1, exrom = 1'b0, key4080 = 1'b1;
  logic [7:0]  dout, ta;
  logic        dout_en, ms0, ms1, ms2, ms3, z80en, fsdir;
  logic [1:0]  ram_bank;

  // Expected entries: {kind[1:0], value[9:0]}
  //   kind 0: {dout_en, dout} (dout ignored when dout_en expected 0)
  //   kind 1: {ms3, ms2, ms1, ms0, z80en, fsdir}
  //   kind 2: {ram_bank, ta}
  //   kind 3: ta only
  logic [11:0] exp_q[$];
  logic        chk_strobe = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  mmu_8722 dut (
    .clk(clk), .reset_n(reset_n), .phi2(phi2), .aec(aec), .rw(rw), .a(a),
    .din(din), .dout(dout), .dout_en(dout_en), .game(game), .exrom(exrom),
    .key4080(key4080), .ms0(ms0), .ms1(ms1), .ms2(ms2), .ms3(ms3),
    .z80en(z80en), .fsdir(fsdir), .ta(ta), .ram_bank(ram_bank)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (chk_strobe) begin
      logic [11:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: sample with empty expected queue at a=%h", a);
      end else begin
        e = exp_q.pop_front();
        case (e[11:10])
          2'd0: begin
            if (dout_en !== e[8] || (e[8] && dout !== e[7:0])) begin
              n_fail++;
              $display("FAIL read a=%h: got en=%b dout=%h, expected en=%b dout=%h",
                       a, dout_en, dout, e[8], e[7:0]);
            end
          end
          2'd1: begin
            if ({ms3, ms2, ms1, ms0, z80en, fsdir} !== e[5:0]) begin
              n_fail++;
              $display("FAIL modes a=%h: got %b, expected %b",
                       a, {ms3, ms2, ms1, ms0, z80en, fsdir}, e[5:0]);
            end
          end
          2'd2: begin
            if ({ram_bank, ta} !== e[9:0]) begin
              n_fail++;
              $display("FAIL xlate a=%h aec=%b: got bank=%0d ta=%h, expected bank=%0d ta=%h",
                       a, aec, ram_bank, ta, e[9:8], e[7:0]);
            end
          end
          default: begin
            if (ta !== e[7:0]) begin
              n_fail++;
              $display("FAIL ta a=%h: got %h, expected %h", a, ta, e[7:0]);
            end
          end
        endcase
      end
    end
  end

  // driver tasks
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    a = addr; din = data; rw = 1'b0; aec = 1'b1; phi2 = 1'b1;
    @(posedge clk); #1;
    phi2 = 1'b0;
    @(posedge clk); #1;
    rw = 1'b1;
  endtask

  task automatic do_check(input logic [15:0] addr, input logic aec_v,
                          input logic [1:0] kind, input logic [9:0] val);
    @(posedge clk); #1;
    a = addr; aec = aec_v; rw = 1'b1; phi2 = 1'b1;
    exp_q.push_back({kind, val});
    chk_strobe = 1'b1;
    @(posedge clk); #1;
    chk_strobe = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, input logic en, input logic [7:0] data);
    do_check(addr, 1'b1, 2'd0, {1'b0, en, data});
  endtask

  task automatic md(input logic [15:0] addr, input logic [5:0] m);
    do_check(addr, 1'b1, 2'd1, {4'b0, m});
  endtask

  task automatic tr(input logic [15:0] addr, input logic aec_v,
                    input logic [1:0] bank, input logic [7:0] t);
    do_check(addr, aec_v, 2'd2, {bank, t});
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; phi2 = 1'b0; rw = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // stimulus
  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset state
    md(16'h0000, 6'b100000);
    rd(16'hFF00, 1'b1, 8'h00);
    rd(16'hD50B, 1'b1, 8'h20);
    rd(16'hD509, 1'b1, 8'h01);
    rd(16'hD505, 1'b1, 8'h96);
    rd(16'hD50C, 1'b1, 8'hFF);

    // CR through both aliases and the {ms1,ms0} table
    cpu_write(16'hFF00, 8'h3E);
    md(16'hC000, 6'b101100);
    md(16'h8000, 6'b101100);
    md(16'h4000, 6'b101100);
    md(16'h0000, 6'b100000);
    rd(16'hD500, 1'b1, 8'h3E);
    cpu_write(16'hFF00, 8'h01);
    rd(16'hD500, 1'b0, 8'h00);
    rd(16'hFF00, 1'b1, 8'h01);
    md(16'h0000, 6'b110000);
    cpu_write(16'hFF00, 8'h00);

    // PCR / LCR load
    cpu_write(16'hD502, 8'h7F);
    cpu_write(16'hFF02, 8'h00);
    rd(16'hFF00, 1'b1, 8'h7F);
    rd(16'hFF02, 1'b1, 8'h7F);
    rd(16'hFF01, 1'b1, 8'h00);
    cpu_write(16'hFF00, 8'h00);

    // page pointer pairing
    cpu_write(16'hD508, 8'h01);
    tr(16'h0045, 1'b1, 2'd0, 8'h00);
    rd(16'hD508, 1'b1, 8'h01);
    rd(16'hD507, 1'b1, 8'h00);
    cpu_write(16'hD507, 8'h13);
    tr(16'h0045, 1'b1, 2'd1, 8'h13);
    tr(16'h1345, 1'b1, 2'd0, 8'h00);
    cpu_write(16'hD50A, 8'h03);
    cpu_write(16'hD508, 8'h02);
    cpu_write(16'hD509, 8'h05);
    tr(16'h0045, 1'b1, 2'd1, 8'h13);
    tr(16'h0100, 1'b1, 2'd3, 8'h05);
    tr(16'h0500, 1'b1, 2'd0, 8'h01);

    // shared RAM and VIC bank
    cpu_write(16'hFF00, 8'h40);
    cpu_write(16'hD506, 8'hC5);
    tr(16'h0200, 1'b1, 2'd0, 8'h02);
    tr(16'h2000, 1'b1, 2'd1, 8'h20);
    tr(16'hF000, 1'b1, 2'd1, 8'hF0);
    tr(16'h0200, 1'b0, 2'd3, 8'h02);
    tr(16'h0045, 1'b0, 2'd3, 8'h00);

    // MCR bits and read-back
    cpu_write(16'hD505, 8'h09);
    rd(16'hD505, 1'b1, 8'h9F);
    md(16'h0000, 6'b100011);
    cpu_write(16'hFF00, 8'h70);
    md(16'hC000, 6'b101111);

    // C64 lock-out
    cpu_write(16'hD505, 8'h40);
    md(16'hC000, 6'b000000);
    cpu_write(16'hFF00, 8'hFF);
    md(16'hC000, 6'b000000);
    rd(16'hFF00, 1'b0, 8'h00);
    rd(16'hD500, 1'b0, 8'h00);
    do_check(16'h0045, 1'b1, 2'd3, 10'h000);

    // reset restores the MMU
    apply_reset();
    md(16'h0000, 6'b100000);
    rd(16'hFF00, 1'b1, 8'h00);
    rd(16'hD509, 1'b1, 8'h01);
    rd(16'hD505, 1'b1, 8'h96);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
